// File: rtl/rv32_mem_responder.sv
// rv32_mem_responder: RAM/MMIO target for the rv32 core, with a boot loader
// that streams a program image in before releasing the core from reset.
//
// state  | meaning
// S_LOAD | core held in reset, loader writes words starting at LOAD_BASE
// S_RUN  | core released, core port serves RAM and MMIO, cycle counter runs
module rv32_mem_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          MEM_WORDS  = 32768,
    parameter int unsigned LOAD_BASE  = 32'h0000_4000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ram_wr_en,
    input  logic [3:0]            ram_wr_strobe,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [31:0]           ram_data_in,
    output logic [31:0]           ram_data_out,
    output logic                  core_reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [31:0]           load_data,
    input  logic                  load_last,
    output logic                  load_overflow,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_overflow,
    output logic                  tohost_valid,
    output logic [31:0]           tohost_data,
    output logic [31:0]           cycle_count
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load_fire;
    logic               r_load_ready;
    logic [31:0]        r_load_addr;
    logic               r_load_overflow;
    logic [31:0]        r_mem [MEM_WORDS];
    logic [31:0]        r_rd_data;
    logic [31:0]        r_tohost_data;
    logic               r_tohost_valid;
    logic [31:0]        r_cycle;
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_tx_overflow;

    logic               w_run;
    logic               w_is_mmio;
    logic [3:0]         w_mmio_off;
    logic               w_core_in_range;
    logic               w_load_in_range;
    logic [3:0]         w_mem_we;
    logic [IDX_W-1:0]   w_mem_idx;
    logic [31:0]        w_mem_wdata;
    logic [31:0]        w_rd_data;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;

    assign w_run           = (r_state == S_RUN);
    assign w_is_mmio       = ram_addr[ADDR_WIDTH-1];
    assign w_mmio_off      = ram_addr[3:0];
    assign w_core_in_range = 32'(ram_addr[ADDR_WIDTH-2:0]) < 32'(MEM_WORDS);
    assign w_load_in_range = r_load_addr < 32'(MEM_WORDS);
    assign w_full          = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty         = (r_count == '0);
    assign w_pop           = !w_empty && tx_ready;
    assign w_push_req      = w_run && ram_wr_en && w_is_mmio && (w_mmio_off == 4'd2) && ram_wr_strobe[0];
    // A simultaneous pop frees the slot first, so a push into a full FIFO still lands.
    assign w_push          = w_push_req && (!w_full || w_pop);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_LOAD;
        else       r_state <= w_next_state;
    end

    // Next-state logic and loader handshake.
    always_comb begin
        w_next_state = r_state;
        w_load_fire  = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (load_valid && r_load_ready) begin
                    w_load_fire = 1'b1;
                    if (load_last) w_next_state = S_RUN;
                end
            end
            S_RUN:   w_next_state = S_RUN;
            default: w_next_state = S_LOAD;
        endcase
    end

    // Loader address, ready and overflow flag; ready is registered so it is low the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_addr     <= LOAD_BASE;
            r_load_ready    <= 1'b0;
            r_load_overflow <= 1'b0;
        end else begin
            r_load_ready <= (w_next_state == S_LOAD);
            if (w_load_fire) begin
                r_load_addr <= r_load_addr + 32'd1;
                if (!w_load_in_range) r_load_overflow <= 1'b1;
            end
        end
    end

    // Single RAM write port shared by the loader (LOAD) and the core (RUN).
    always_comb begin
        w_mem_we    = 4'b0000;
        w_mem_idx   = ram_addr[IDX_W-1:0];
        w_mem_wdata = ram_data_in;
        if (w_load_fire) begin
            w_mem_idx   = r_load_addr[IDX_W-1:0];
            w_mem_wdata = load_data;
            if (w_load_in_range) w_mem_we = 4'b1111;
        end else if (w_run && ram_wr_en && !w_is_mmio && w_core_in_range) begin
            w_mem_we = ram_wr_strobe;
        end
    end

    // Byte-lane RAM write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_mem_we[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
        end
    end

    // Read mux over RAM and MMIO registers, sampled before this cycle's updates.
    always_comb begin
        w_rd_data = 32'd0;
        if (w_is_mmio) begin
            case (w_mmio_off)
                4'd0:    w_rd_data = r_tohost_data;
                4'd1:    w_rd_data = r_cycle;
                4'd2:    w_rd_data = {31'd0, w_full};
                default: w_rd_data = 32'd0;
            endcase
        end else if (w_core_in_range) begin
            w_rd_data = r_mem[ram_addr[IDX_W-1:0]];
        end
    end

    // Registered read data; held at zero while loading.
    always_ff @(posedge clk) begin
        if (reset)      r_rd_data <= 32'd0;
        else if (w_run) r_rd_data <= w_rd_data;
        else            r_rd_data <= 32'd0;
    end

    // Cycle counter and tohost register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle        <= 32'd0;
            r_tohost_data  <= 32'd0;
            r_tohost_valid <= 1'b0;
        end else begin
            if (w_run) r_cycle <= r_cycle + 32'd1;
            if (w_run && ram_wr_en && w_is_mmio && (w_mmio_off == 4'd0)) begin
                r_tohost_data  <= ram_data_in;
                r_tohost_valid <= 1'b1;
            end
        end
    end

    // Console FIFO: pointers wrap modulo FIFO_DEPTH, separate occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tx_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= ram_data_in[7:0];
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push_req && !w_push) r_tx_overflow <= 1'b1;
        end
    end

    assign ram_data_out  = r_rd_data;
    assign core_reset_n  = w_run;
    assign load_ready    = r_load_ready;
    assign load_overflow = r_load_overflow;
    assign tx_valid      = !w_empty;
    assign tx_data       = r_fifo[r_rd_ptr];
    assign tx_overflow   = r_tx_overflow;
    assign tohost_valid  = r_tohost_valid;
    assign tohost_data   = r_tohost_data;
    assign cycle_count   = r_cycle;

endmodule

// File: tb/tb_rv32_mem_responder.sv
// Directed bench for rv32_mem_responder: full-size instance plus a small
// instance (64 words, loader starting at the last word) for loader overflow.
module tb_rv32_mem_responder;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        ram_wr_en;
    logic [3:0]  ram_wr_strobe;
    logic [15:0] ram_addr;
    logic [31:0] ram_data_in;
    logic        load_valid, load_valid2, load_last;
    logic [31:0] load_data;
    logic        tx_ready;

    logic [31:0] ram_data_out, ram_data_out_2;
    logic        core_reset_n, core_reset_n_2;
    logic        load_ready, load_ready_2;
    logic        load_overflow, load_overflow_2;
    logic        tx_valid, tx_valid_2;
    logic [7:0]  tx_data, tx_data_2;
    logic        tx_overflow, tx_overflow_2;
    logic        tohost_valid, tohost_valid_2;
    logic [31:0] tohost_data, tohost_data_2;
    logic [31:0] cycle_count, cycle_count_2;

    int          total = 0;
    int          bad   = 0;
    int unsigned model_cycle = 0;
    int          popped_n = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] v0, v1;

    always #5 clk = ~clk;

    rv32_mem_responder dut (
        .clk(clk), .reset(reset),
        .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .core_reset_n(core_reset_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .load_overflow(load_overflow),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_overflow(tx_overflow),
        .tohost_valid(tohost_valid), .tohost_data(tohost_data), .cycle_count(cycle_count)
    );

    rv32_mem_responder #(.ADDR_WIDTH(16), .MEM_WORDS(64), .LOAD_BASE(63), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset2),
        .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out_2), .core_reset_n(core_reset_n_2),
        .load_valid(load_valid2), .load_ready(load_ready_2), .load_data(load_data),
        .load_last(load_last), .load_overflow(load_overflow_2),
        .tx_valid(tx_valid_2), .tx_ready(1'b0), .tx_data(tx_data_2), .tx_overflow(tx_overflow_2),
        .tohost_valid(tohost_valid_2), .tohost_data(tohost_data_2), .cycle_count(cycle_count_2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score console pops, track the expected cycle counter, step.
    task automatic tick();
        logic [7:0] e;
        if (tx_valid && tx_ready) begin
            popped_n++;
            if (tx_q.size() == 0) begin
                total++; bad++;
                $error("FAIL tx_extra: observed=%h expected=none", tx_data);
            end else begin
                e = tx_q.pop_front();
                check("tx_data", {24'd0, tx_data}, {24'd0, e});
            end
        end
        if (reset) model_cycle = 0;
        else if (core_reset_n) model_cycle++;
        @(posedge clk); #1;
    endtask

    // Drive one core-port cycle; optionally score the read data one cycle later.
    task automatic core_op(input bit d2, input bit we, input logic [3:0] strb, input logic [15:0] addr,
                           input logic [31:0] wdata, input bit chk, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        ram_wr_en = we; ram_wr_strobe = strb; ram_addr = addr; ram_data_in = wdata;
        if (chk) rd_q.push_back(exp);
        tick();
        ram_wr_en = 1'b0; ram_wr_strobe = 4'b0000;
        if (chk) begin
            e = rd_q.pop_front();
            check(tag, d2 ? ram_data_out_2 : ram_data_out, e);
        end
    endtask

    task automatic rd(input bit d2, input logic [15:0] addr, input logic [31:0] exp, input string tag);
        core_op(d2, 1'b0, 4'b0000, addr, 32'd0, 1'b1, exp, tag);
    endtask

    // Console write: the bench model decides whether the byte is kept.
    task automatic con_write(input logic [7:0] b);
        int  occ;
        bit  full_before;
        occ = tx_q.size();
        full_before = (occ == 4);
        if (tx_valid && tx_ready) occ--;
        if (occ < 4) tx_q.push_back(b);
        core_op(1'b0, 1'b1, 4'b0001, 16'h8002, {24'hABCDEF, b}, 1'b1, {31'd0, full_before}, "console_status");
    endtask

    task automatic load_word(input bit d2, input logic [31:0] data, input bit last);
        bit done;
        done = 1'b0;
        load_data = data; load_last = last;
        if (d2) load_valid2 = 1'b1; else load_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (d2 ? load_ready_2 : load_ready) done = 1'b1;
            tick();
        end
        load_valid = 1'b0; load_valid2 = 1'b0; load_last = 1'b0;
        if (!done) begin
            total++; bad++;
            $error("FAIL load_timeout: observed=no_ready expected=ready");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        ram_wr_en = 1'b0; ram_wr_strobe = 4'b0000; ram_addr = 16'h0000; ram_data_in = 32'd0;
        load_valid = 1'b0; load_valid2 = 1'b0; load_last = 1'b0; load_data = 32'd0;
        tx_ready = 1'b0;
        repeat (3) tick();

        check("rst_core_reset_n", {31'd0, core_reset_n}, 32'd0);
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("rst_data_out", ram_data_out, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_flags", {28'd0, load_overflow, tx_overflow, tohost_valid, 1'b0}, 32'd0);
        check("rst_tohost_data", tohost_data, 32'd0);
        check("rst_cycle", cycle_count, 32'd0);

        // Small instance: loader starts at the last word, second word overflows.
        reset2 = 1'b0;
        load_word(1'b1, 32'h1111_1111, 1'b0);
        check("d2_ovf_after_first", {31'd0, load_overflow_2}, 32'd0);
        check("d2_core_rst_mid", {31'd0, core_reset_n_2}, 32'd0);
        load_word(1'b1, 32'h2222_2222, 1'b1);
        check("d2_ovf_after_second", {31'd0, load_overflow_2}, 32'd1);
        check("d2_core_released", {31'd0, core_reset_n_2}, 32'd1);
        rd(1'b1, 16'd63, 32'h1111_1111, "d2_last_word");
        ram_addr = 16'd0;
        tick();
        total++;
        assert (ram_data_out_2 !== 32'h2222_2222) else begin
            bad++;
            $error("FAIL d2_no_wrap: observed=%h expected=not 22222222", ram_data_out_2);
        end
        core_op(1'b1, 1'b1, 4'b1111, 16'd0, 32'h0000_AAAA, 1'b0, 32'd0, "");
        core_op(1'b1, 1'b1, 4'b1111, 16'd64, 32'hDEAD_BEEF, 1'b0, 32'd0, "");
        rd(1'b1, 16'd0, 32'h0000_AAAA, "d2_word0");
        rd(1'b1, 16'd64, 32'd0, "d2_out_of_range");
        reset2 = 1'b1;

        // Main instance: load three words.
        reset = 1'b0;
        ram_addr = 16'h4000;
        check("load_ready_first_cycle", {31'd0, load_ready}, 32'd0);
        load_word(1'b0, 32'h0000_0537, 1'b0);
        check("load_data_out_zero", ram_data_out, 32'd0);
        load_word(1'b0, 32'h0015_0513, 1'b0);
        check("load_core_rst_before", {31'd0, core_reset_n}, 32'd0);
        check("load_ready_mid", {31'd0, load_ready}, 32'd1);
        load_word(1'b0, 32'h0000_006F, 1'b1);
        check("load_core_rst_after", {31'd0, core_reset_n}, 32'd1);
        check("load_ready_after", {31'd0, load_ready}, 32'd0);
        check("load_no_overflow", {31'd0, load_overflow}, 32'd0);
        check("cycle_at_release", cycle_count, model_cycle);

        // RAM reads and byte-strobed writes.
        rd(1'b0, 16'h4000, 32'h0000_0537, "rd_4000");
        rd(1'b0, 16'h4001, 32'h0015_0513, "rd_4001");
        rd(1'b0, 16'h4002, 32'h0000_006F, "rd_4002");
        core_op(1'b0, 1'b1, 4'b0100, 16'h4001, 32'hAABB_CCDD, 1'b1, 32'h0015_0513, "wr_read_old");
        rd(1'b0, 16'h4001, 32'h00BB_0513, "rd_after_strobe");
        core_op(1'b0, 1'b1, 4'b1111, 16'h0010, 32'h1234_5678, 1'b0, 32'd0, "");
        core_op(1'b0, 1'b1, 4'b0000, 16'h0010, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, "wr_full_word");
        rd(1'b0, 16'h0010, 32'h1234_5678, "strobe_none");
        core_op(1'b0, 1'b1, 4'b1001, 16'h0010, 32'hAA00_00BB, 1'b0, 32'd0, "");
        rd(1'b0, 16'h0010, 32'hAA34_56BB, "strobe_1001");

        // Console FIFO fill, overflow, push-while-full-with-pop, drain.
        con_write(8'h48); con_write(8'h69); con_write(8'h41); con_write(8'h42);
        check("con_valid", {31'd0, tx_valid}, 32'd1);
        check("con_head", {24'd0, tx_data}, 32'h48);
        check("con_no_ovf", {31'd0, tx_overflow}, 32'd0);
        con_write(8'h43);
        check("con_ovf", {31'd0, tx_overflow}, 32'd1);
        rd(1'b0, 16'h8002, 32'd1, "con_full_status");
        tx_ready = 1'b1;
        con_write(8'h44);
        repeat (6) tick();
        tx_ready = 1'b0;
        check("con_popped", popped_n, 32'd5);
        check("con_empty", {31'd0, tx_valid}, 32'd0);
        rd(1'b0, 16'h8002, 32'd0, "con_status_empty");

        // Cycle counter and tohost.
        rd(1'b0, 16'h8001, model_cycle, "cycle_rd0");
        v0 = ram_data_out;
        repeat (9) tick();
        rd(1'b0, 16'h8001, model_cycle, "cycle_rd1");
        v1 = ram_data_out;
        check("cycle_delta", v1 - v0, 32'd10);
        core_op(1'b0, 1'b1, 4'b0001, 16'h8000, 32'd1, 1'b1, 32'd0, "tohost_wr_old");
        check("tohost_valid", {31'd0, tohost_valid}, 32'd1);
        check("tohost_data", tohost_data, 32'd1);
        rd(1'b0, 16'h8000, 32'd1, "tohost_rd");
        rd(1'b0, 16'h8005, 32'd0, "mmio_other");

        // Reset mid-RUN with the FIFO non-empty.
        con_write(8'h78); con_write(8'h79);
        check("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
        reset = 1'b1;
        tx_q.delete();
        tick();
        check("midrun_core_rst", {31'd0, core_reset_n}, 32'd0);
        check("midrun_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("midrun_flags", {30'd0, tx_overflow, tohost_valid}, 32'd0);
        check("midrun_cycle", cycle_count, 32'd0);

        // Reset mid-LOAD after one word; next load restarts at LOAD_BASE.
        reset = 1'b0;
        load_word(1'b0, 32'hCAFE_0001, 1'b0);
        reset = 1'b1;
        tick();
        check("midload_core_rst", {31'd0, core_reset_n}, 32'd0);
        check("midload_load_ready", {31'd0, load_ready}, 32'd0);
        reset = 1'b0;
        load_word(1'b0, 32'hBEEF_0002, 1'b1);
        check("reload_core_rst", {31'd0, core_reset_n}, 32'd1);
        rd(1'b0, 16'h4000, 32'hBEEF_0002, "reload_4000");
        rd(1'b0, 16'h4001, 32'h00BB_0513, "reload_4001");
        rd(1'b0, 16'h4002, 32'h0000_006F, "reload_4002");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_mem_responder.md
Name: rv32_mem_responder

Overview:
- Target side of the rv32 core RAM interface: word-addressed, byte-strobed, 1-cycle synchronous-read memory plus a small MMIO window (cycle counter, console FIFO, tohost).
- Includes a boot loader port that streams a program image into memory before releasing the core.
- Sits between the core's ram_* port and the testbench/SoC top; it is the only owner of core reset release.

Parameters:
- ADDR_WIDTH, 16, word-address width of the core port; bit ADDR_WIDTH-1 selects MMIO (1) vs RAM (0).
- MEM_WORDS, 32768, RAM depth in 32-bit words; must satisfy MEM_WORDS <= 2**(ADDR_WIDTH-1).
- LOAD_BASE, 16'h4000, first word address written by the loader (byte 0x10000 >> 2).
- FIFO_DEPTH, 4, console FIFO entries; power of two.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ram_wr_en  in  1  write request from core
- ram_wr_strobe  in  4  byte-lane enables; bit i enables byte lane [8i+7:8i]
- ram_addr  in  ADDR_WIDTH  word address from core
- ram_data_in  in  32  write data, already lane-aligned by core
- ram_data_out  out  32  registered read data
- core_reset_n  out  1  active-low reset to core; low until the loader finishes
- load_valid  in  1  loader word valid
- load_ready  out  1  loader can accept a word
- load_data  in  32  loader word
- load_last  in  1  marks final loader word
- load_overflow  out  1  sticky: loader word dropped because the address reached MEM_WORDS
- tx_valid  out  1  console byte available
- tx_ready  in  1  console sink accepts byte
- tx_data  out  8  console byte
- tx_overflow  out  1  sticky: console write dropped because the FIFO was full
- tohost_valid  out  1  sticky: core wrote tohost
- tohost_data  out  32  value written to tohost
- cycle_count  out  32  free-running cycles since the core was released

Behaviour:
- Reset values:
  - state=LOAD; ram_data_out=0; core_reset_n=0; load_ready=0 (first cycle after reset); load address=LOAD_BASE.
  - load_overflow=0; tx_valid=0; tx_data=0; tx_overflow=0; tohost_valid=0; tohost_data=0; cycle_count=0.
  - FIFO empty. RAM contents are not reset.
- States:
  - LOAD:
    - load_ready=1.
    - On load_valid&&load_ready: if load address < MEM_WORDS, write all 4 lanes; otherwise drop the word and set load_overflow. Increment the load address either way.
    - If load_last is set on the accepted word, go to RUN on the next cycle.
    - Core port is ignored (no writes, ram_data_out holds 0).
  - RUN:
    - core_reset_n=1 registered (goes high the cycle after the last word is accepted); load_ready=0; load inputs ignored.
    - cycle_count increments every RUN cycle and wraps at 2^32.
  - There is no exit from RUN except reset.
- Read timing (RUN):
  - ram_data_out <= read(ram_addr) every cycle, regardless of ram_wr_en. Latency is exactly 1 cycle.
  - Same-cycle write+read of the same word returns the OLD data.
- RAM region (addr[ADDR_WIDTH-1]==0):
  - Words < MEM_WORDS are read/write.
  - Words >= MEM_WORDS read 0 and ignore writes.
- Writes (RUN, ram_wr_en=1): only lanes with a set strobe bit are updated; strobe 0000 is a no-op.
- MMIO region (addr[ADDR_WIDTH-1]==1), offset = addr[3:0]:
  - Offset 0 TOHOST:
    - Write of any strobe: tohost_data <= ram_data_in and tohost_valid <= 1.
    - Read returns tohost_data.
  - Offset 1 CYCLE:
    - Read returns cycle_count (the value before the increment in that cycle).
    - Writes are ignored.
  - Offset 2 CONSOLE:
    - A write with strobe[0]=1 pushes ram_data_in[7:0]; if the FIFO is full, drop the byte and set tx_overflow.
    - Read returns {31'b0, fifo_full}.
  - Other offsets read 0 and ignore writes.
- Console FIFO:
  - tx_valid = !empty; tx_data = head byte; pop on tx_valid&&tx_ready.
  - Push and pop in the same cycle while full: the pop frees the slot first, so the push succeeds and no overflow is flagged.
  - Push and pop in the same cycle while empty: the pushed byte is presented the following cycle.
  - Occupancy counter is ADDR-independent and wraps modulo FIFO_DEPTH on the pointers.
- Reset mid-operation: everything returns to LOAD immediately; core_reset_n drops the same cycle reset is sampled; the FIFO is flushed; the load address returns to LOAD_BASE.

Test Plan:
- Load 3 words {0x00000537,0x00150513,0x0000006F} with load_last on the 3rd -> RAM[0x4000..0x4002] hold them; core_reset_n rises exactly 1 cycle after the 3rd handshake; load_ready falls.
- RUN, ram_addr=0x4001 -> ram_data_out=0x00150513 on the next edge. Then write 0xAABBCCDD strobe 0100 to 0x4001 -> a later read returns 0x00BB0513. A read issued in the write cycle returns 0x00150513.
- Write bytes 'H','i' to CONSOLE (addr 0x8002, strobe 0001) with tx_ready=0, then 3 more bytes -> tx_valid=1, 4 bytes queued, 5th dropped, tx_overflow=1. With FIFO full, assert tx_ready and push in the same cycle -> no overflow; pop order is preserved.
- Read CYCLE (0x8001) on two reads 10 cycles apart -> the values differ by 10. Write 0x00000001 to TOHOST (0x8000) -> tohost_valid=1, tohost_data=1.
- Loader starting at LOAD_BASE=MEM_WORDS-1: send 2 words -> the first is stored, the second is dropped, load_overflow=1; RAM address 0 is untouched (no wrap).
- Assert reset mid-load after 1 word and again mid-RUN with the FIFO non-empty -> core_reset_n=0, tx_valid=0, state=LOAD; the next load restarts at LOAD_BASE.
